// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and helpers for the stopwatch timekeeping slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DIGIT_W = 5;

    localparam logic [3:0] CS_MAX       = 4'd9;
    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;

    typedef logic [3:0] bcd_t;

    // Index 0 = cs ones ... index 5 = min tens.
    typedef logic [5:0][3:0] digits_t;

    function automatic bcd_t bcd_next(input bcd_t val, input bcd_t max, input logic inc);
        if (!inc) begin
            return val;
        end
        return (val == max) ? 4'd0 : val + 4'd1;
    endfunction

    function automatic logic [6*DIGIT_W-1:0] pack_digits(input digits_t d);
        logic [6*DIGIT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*DIGIT_W +: DIGIT_W] = {1'b0, d[i]};
        end
        return r;
    endfunction

    function automatic logic [5:0] blank_mask(input bcd_t min_tens, input bcd_t min_ones,
                                              input logic blank_en);
        if (!blank_en) begin
            return 6'b111111;
        end
        return {min_tens != 4'd0, (min_tens != 4'd0) || (min_ones != 4'd0), 4'b1111};
    endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit of the stopwatch cascade: wraps at MAX and reports a carry.
module bcd_digit_ctr
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] val,
    output logic       carry
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (inc) begin
            val <= bcd_next(val, MAX, 1'b1);
        end
    end

    assign carry = inc && (val == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: button edges, 10 ms prescaler, MM:SS.cc BCD count, display drive.
// Optional lap display hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [29:0] digit_val,
    output logic [5:0]  digit_en,
    output logic        running,
    output logic        overflow
);

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [5:0]         EN_RESET   = BLANK_EN ? 6'b001111 : 6'b111111;

    state_t             state;
    state_t             state_nxt;
    logic               start_stop_q;
    logic               clear_q;
    logic               ss_rise;
    logic               clr_rise;
    logic               enter_idle;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [5:0]         inc;
    logic [5:0]         carry;
    digits_t            live;
    digits_t            live_nxt;
    digits_t            shown;

    assign ss_rise    = start_stop & ~start_stop_q;
    assign clr_rise   = clear & ~clear_q;
    assign enter_idle = (state == STOP) && clr_rise;
    assign tick       = (state == RUN) && (presc == PRESC_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_rise) state_nxt = RUN;
            RUN:     if (ss_rise) state_nxt = STOP;
            STOP: begin
                if (clr_rise) begin
                    state_nxt = IDLE;
                end else if (ss_rise) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            start_stop_q <= 1'b0;
            clear_q      <= 1'b0;
            presc        <= '0;
            running      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_stop_q <= start_stop;
            clear_q      <= clear;
            running      <= (state_nxt == RUN);
            if (enter_idle) begin
                presc    <= '0;
                overflow <= 1'b0;
            end else if (state == RUN) begin
                presc <= tick ? '0 : presc + PRESC_W'(1);
                if (carry[5]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Carry chain: each digit advances only when every lower digit wraps.
    assign inc[0] = tick;
    assign inc[1] = carry[0];
    assign inc[2] = carry[1];
    assign inc[3] = carry[2];
    assign inc[4] = carry[3];
    assign inc[5] = carry[4];

    bcd_digit_ctr #(.MAX(CS_MAX)) u_cs_ones (
        .clk(clk), .rst(rst), .clr(enter_idle), .inc(inc[0]), .val(live[0]), .carry(carry[0])
    );
    bcd_digit_ctr #(.MAX(CS_MAX)) u_cs_tens (
        .clk(clk), .rst(rst), .clr(enter_idle), .inc(inc[1]), .val(live[1]), .carry(carry[1])
    );
    bcd_digit_ctr #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(enter_idle), .inc(inc[2]), .val(live[2]), .carry(carry[2])
    );
    bcd_digit_ctr #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(enter_idle), .inc(inc[3]), .val(live[3]), .carry(carry[3])
    );
    bcd_digit_ctr #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(enter_idle), .inc(inc[4]), .val(live[4]), .carry(carry[4])
    );
    bcd_digit_ctr #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(enter_idle), .inc(inc[5]), .val(live[5]), .carry(carry[5])
    );

    // Mirror of the counters' next values so the output registers stay in step with them.
    always_comb begin
        live_nxt = '0;
        if (!enter_idle) begin
            live_nxt[0] = bcd_next(live[0], CS_MAX, inc[0]);
            live_nxt[1] = bcd_next(live[1], CS_MAX, inc[1]);
            live_nxt[2] = bcd_next(live[2], SEC_ONES_MAX, inc[2]);
            live_nxt[3] = bcd_next(live[3], SEC_TENS_MAX, inc[3]);
            live_nxt[4] = bcd_next(live[4], MIN_ONES_MAX, inc[4]);
            live_nxt[5] = bcd_next(live[5], MIN_TENS_MAX, inc[5]);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic    lap_q;
    logic    lap_rise;
    logic    hold;
    logic    hold_nxt;
    digits_t snap;
    digits_t snap_nxt;

    assign lap_rise = lap & ~lap_q;

    // The snapshot is the live count as it stood when the lap edge was sampled.
    always_comb begin
        hold_nxt = hold;
        snap_nxt = snap;
        if (enter_idle) begin
            hold_nxt = 1'b0;
        end else if (lap_rise && (state == RUN)) begin
            hold_nxt = ~hold;
            if (!hold) begin
                snap_nxt = live;
            end
        end else if (lap_rise && (state == STOP)) begin
            hold_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            hold  <= 1'b0;
        end else begin
            lap_q <= lap;
            hold  <= hold_nxt;
        end
    end

    always_ff @(posedge clk) begin
        snap <= snap_nxt;
    end

    assign shown = hold_nxt ? snap_nxt : live_nxt;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign shown      = live_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_val <= '0;
            digit_en  <= EN_RESET;
        end else begin
            digit_val <= pack_digits(shown);
            digit_en  <= blank_mask(shown[5], shown[4], BLANK_EN);
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a centisecond-count model feeds an expectation queue.
module tb_stopwatch_core;

    localparam int TD      = 4;
    localparam int CNT_MAX = 359999;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [29:0] digit_val;
    logic [5:0]  digit_en;
    logic        running;
    logic        overflow;

    stopwatch_core #(.TICK_DIV(TD), .BLANK_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .digit_val(digit_val), .digit_en(digit_en), .running(running), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] val;
        logic [5:0]  en;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;

    // Model: state 0=idle 1=run 2=stop, count held as total centiseconds.
    int m_state, m_presc, m_cnt, m_snap;
    bit m_ovf, m_hold, m_ss_q, m_clr_q, m_lap_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [29:0] digits_of(input int c);
        int cs, s, m;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        return {5'(m / 10), 5'(m % 10), 5'(s / 10), 5'(s % 10), 5'(cs / 10), 5'(cs % 10)};
    endfunction

    function automatic logic [5:0] en_of(input int c);
        int m;
        m = c / 6000;
        return {m >= 10, m >= 1, 4'b1111};
    endfunction

    task automatic model_reset();
        m_state = 0; m_presc = 0; m_cnt = 0; m_snap = 0;
        m_ovf = 0; m_hold = 0; m_ss_q = 0; m_clr_q = 0; m_lap_q = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp, output exp_t e);
        bit ssr, clr;
        int nst, pre, shown;
        ssr = ss && !m_ss_q;
        clr = cl && !m_clr_q;
        nst = m_state;
        if (m_state == 0 && ssr) nst = 1;
        else if (m_state == 1 && ssr) nst = 2;
        else if (m_state == 2 && clr) nst = 0;
        else if (m_state == 2 && ssr) nst = 1;
        pre = m_cnt;
        if (m_state == 1) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                if (m_cnt == CNT_MAX) begin
                    m_cnt = 0;
                    m_ovf = 1;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_presc++;
            end
        end
`ifdef STOPWATCH_LAP_EN
        if (lp && !m_lap_q && m_state == 1) begin
            m_hold = !m_hold;
            if (m_hold) m_snap = pre;
        end else if (lp && !m_lap_q && m_state == 2) begin
            m_hold = 0;
        end
`else
        if (pre < 0) m_hold = 0;
`endif
        if (m_state == 2 && clr) begin
            m_presc = 0; m_cnt = 0; m_ovf = 0; m_hold = 0;
        end
        m_state = nst;
        m_ss_q  = ss;
        m_clr_q = cl;
        m_lap_q = lp;
        shown   = m_hold ? m_snap : m_cnt;
        e.val = digits_of(shown);
        e.en  = en_of(shown);
        e.run = (nst == 1);
        e.ovf = m_ovf;
    endtask

    task automatic cycle(input bit ss, input bit cl, input bit lp);
        exp_t e;
        @(negedge clk);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        model_step(ss, cl, lp, e);
        expq.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Load 59:59.99 into the stopped counters; caller guarantees the model is in STOP.
    task automatic force_max();
        exp_t e;
        @(negedge clk);
        force dut.u_cs_ones.val  = 4'd9;
        force dut.u_cs_tens.val  = 4'd9;
        force dut.u_sec_ones.val = 4'd9;
        force dut.u_sec_tens.val = 4'd5;
        force dut.u_min_ones.val = 4'd9;
        force dut.u_min_tens.val = 4'd5;
        m_cnt = CNT_MAX;
        start_stop = 0; clear = 0; lap = 0;
        model_step(1'b0, 1'b0, 1'b0, e);
        expq.push_back(e);
        @(negedge clk);
        release dut.u_cs_ones.val;
        release dut.u_cs_tens.val;
        release dut.u_sec_ones.val;
        release dut.u_sec_tens.val;
        release dut.u_min_ones.val;
        release dut.u_min_tens.val;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("digit_val", {2'b0, digit_val}, {2'b0, e.val});
            chk("digit_en", {26'b0, digit_en}, {26'b0, e.en});
            chk("running", {31'b0, running}, {31'b0, e.run});
            chk("overflow", {31'b0, overflow}, {31'b0, e.ovf});
        end
    end

    initial begin
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_val", {2'b0, digit_val}, 32'd0);
        chk("reset_en", {26'b0, digit_en}, 32'b001111);
        chk("reset_run", {31'b0, running}, 32'd0);
        chk("reset_ovf", {31'b0, overflow}, 32'd0);
        rst = 1'b0;

        // Start, count 40 cycles through the first cs tens carry.
        cycle(1, 0, 0);
        idle_cycles(40);
        // Held start_stop: exactly one transition to STOP, digits frozen.
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        idle_cycles(5);
        cycle(1, 0, 0);
        idle_cycles(7);
        // Clear ignored while running.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        idle_cycles(3);
        // Stop, then simultaneous start_stop + clear from STOP goes to IDLE.
        cycle(1, 0, 0);
        idle_cycles(3);
        cycle(1, 1, 0);
        idle_cycles(4);

        // Wrap-around at 59:59.99 and overflow clearing.
        cycle(1, 0, 0);
        idle_cycles(9);
        cycle(1, 0, 0);
        idle_cycles(1);
        force_max();
        idle_cycles(2);
        cycle(1, 0, 0);
        idle_cycles(12);
        cycle(1, 0, 0);
        idle_cycles(3);
        cycle(0, 1, 0);
        idle_cycles(3);

        // Lap hold while running (effective only in lap builds).
        cycle(1, 0, 0);
        idle_cycles(491);
        cycle(0, 0, 1);
        idle_cycles(320);
        cycle(0, 0, 1);
        idle_cycles(20);

        // Asynchronous reset mid-run.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_val", {2'b0, digit_val}, 32'd0);
        chk("async_en", {26'b0, digit_en}, 32'b001111);
        chk("async_run", {31'b0, running}, 32'd0);
        chk("async_ovf", {31'b0, overflow}, 32'd0);
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        start_stop = 0; clear = 0; lap = 0;
        model_reset();
        idle_cycles(10);

        // Randomized button activity.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom % 16) == 0, ($urandom % 24) == 0, ($urandom % 40) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
